infer_div_sdiv_36s_21s_15_seq: RTL

Sequential signed divider, the inverse of the datapath's pipelined 15s×21s→36 multiplier. It takes a 36-bit signed product-domain value and a 21-bit signed divisor and returns a 15-bit signed quotient plus a 21-bit signed remainder. Used where inference stages rescale accumulated products back to operand width. Radix-2 iterative core with valid/ready handshakes on both sides, fixed latency and one operation in flight.

---
 rtl/infer_div_sdiv_36s_21s_15_seq.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/infer_div_sdiv_36s_21s_15_seq.sv
// -----------------------------------------------------------------------------
// infer_div_sdiv_36s_21s_15_seq
//
// Sequential signed divider: 36-bit signed dividend / 21-bit signed divisor ->
// 15-bit signed quotient (truncated toward zero) and 21-bit signed remainder
// (sign of the dividend). Radix-2 restoring core, one operation in flight,
// fixed latency independent of operand values.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   ce         clock enable; low freezes all state and outputs
//   in_valid   operands valid          in_ready   divider can accept operands
//   dividend   signed dividend         divisor    signed divisor
//   out_valid  result valid            out_ready  consumer accepts result
//   quotient   signed quotient         remainder  signed remainder
//   ovf        quotient does not fit QUOTIENT_WIDTH
//   dz         divisor was zero
//
// Build option:
//   INFER_DIV_SAT_EN  defined   -> quotient saturates on overflow / divide by zero
//                     undefined -> quotient wraps on overflow, -1 on divide by zero
// -----------------------------------------------------------------------------
module infer_div_sdiv_36s_21s_15_seq #(
  parameter int DIVIDEND_WIDTH = 36,
  parameter int DIVISOR_WIDTH  = 21,
  parameter int QUOTIENT_WIDTH = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ce,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
  input  logic signed [DIVISOR_WIDTH-1:0]  divisor,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [QUOTIENT_WIDTH-1:0] quotient,
  output logic signed [DIVISOR_WIDTH-1:0]  remainder,
  output logic                             ovf,
  output logic                             dz
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int QW = QUOTIENT_WIDTH;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Datapath registers (not reset; only meaningful between accept and FIX)
  logic [DW-1:0]     quo_q;      // dividend magnitude shifting out, quotient bits shifting in
  logic [VW-1:0]     rem_q;      // partial remainder magnitude
  logic [VW-1:0]     dmag_q;     // divisor magnitude
  logic              qneg_q;     // quotient sign
  logic              rneg_q;     // remainder sign (dividend sign)
  logic              dzop_q;     // current operation divides by zero
  logic [VW-1:0]     lo_q;       // dividend low bits, the remainder on divide by zero

  // Result registers (reset)
  logic signed [QW-1:0] quotient_q, quotient_d;
  logic signed [VW-1:0] remainder_q, remainder_d;
  logic                 ovf_q, ovf_d;
  logic                 dz_q;

  // Magnitudes are taken as unsigned values, so the most negative input maps
  // to 2^(W-1) without wrapping.
  function automatic logic [DW-1:0] mag_dvd(input logic [DW-1:0] v);
    return v[DW-1] ? (~v) + DW'(1) : v;
  endfunction

  function automatic logic [VW-1:0] mag_dvs(input logic [VW-1:0] v);
    return v[VW-1] ? (~v) + VW'(1) : v;
  endfunction

`ifdef INFER_DIV_SAT_EN
  function automatic logic [QW-1:0] sat_q(input logic neg);
    return neg ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ce) begin
      case (state_q)
        IDLE: if (in_valid) begin
          state_d = CALC;
          cnt_d   = CW'(DW - 1);
        end
        CALC: begin
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - CW'(1);
        end
        FIX:  state_d = DONE;
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // ---------------------------------------------------------------------------
  // Restoring step: shift {rem, quo} left, trial-subtract divisor magnitude
  // ---------------------------------------------------------------------------
  logic [VW:0]   rem_sh;
  logic [VW:0]   trial;
  logic          take;
  logic [VW-1:0] rem_d;

  // rem_q < dmag_q <= 2^(VW-1), so rem_sh < 2^VW and trial[VW] is the borrow.
  always_comb begin
    rem_sh = {rem_q, quo_q[DW-1]};
    trial  = rem_sh - {1'b0, dmag_q};
    take   = ~trial[VW];
    rem_d  = take ? trial[VW-1:0] : rem_sh[VW-1:0];
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      case (state_q)
        IDLE: if (in_valid) begin
          quo_q  <= mag_dvd(dividend);
          rem_q  <= '0;
          dmag_q <= mag_dvs(divisor);
          qneg_q <= dividend[DW-1] ^ divisor[VW-1];
          rneg_q <= dividend[DW-1];
          dzop_q <= (divisor == '0);
          lo_q   <= dividend[VW-1:0];
        end
        CALC: begin
          quo_q <= {quo_q[DW-2:0], take};
          rem_q <= rem_d;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sign fix-up, range check and result select
  // ---------------------------------------------------------------------------
  logic signed [DW:0] q_full;
  logic               q_fits;

  always_comb begin
    q_full = qneg_q ? -{1'b0, quo_q} : {1'b0, quo_q};
    // The value fits QW signed bits iff all bits from QW-1 upward agree.
    q_fits = (&q_full[DW:QW-1]) | ~(|q_full[DW:QW-1]);

    quotient_d  = q_full[QW-1:0];
    remainder_d = rneg_q ? -rem_q : rem_q;
    ovf_d       = ~q_fits;

    if (dzop_q) begin
      ovf_d       = 1'b0;
      remainder_d = lo_q;
`ifdef INFER_DIV_SAT_EN
      quotient_d  = sat_q(rneg_q);
`else
      quotient_d  = '1;
`endif
    end else if (!q_fits) begin
`ifdef INFER_DIV_SAT_EN
      quotient_d  = sat_q(q_full[DW]);
`else
      quotient_d  = q_full[QW-1:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else if (ce && state_q == FIX) begin
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      ovf_q       <= ovf_d;
      dz_q        <= dzop_q;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule
